decode_stage_fwd: RTL and testbench

- Second-generation RV32 decode stage with a registered ID/EX output and a valid/ready handshake on both sides.
- Replaces stall-on-any-hazard with per-operand forwarding from NUM_FWD parametrised bypass channels; stalls only when the needed data is not yet produced.
- Adds flush, an illegal-opcode flag and a saturating stall counter.
- Sits between fetch and execute; reads the register file combinationally.

---
 rtl/decode_stage_fwd.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_decode_stage_fwd.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_fwd.sv
// RV32 decode stage with a registered ID/EX output, valid/ready handshake on
// both sides, per-operand forwarding from NUM_FWD bypass channels, flush,
// illegal-opcode flag and a saturating stall counter.

package decode_stage_fwd_pkg;
    typedef enum logic [2:0] {
        NO_TYPE = 3'd0,
        R_TYPE  = 3'd1,
        I_TYPE  = 3'd2,
        S_TYPE  = 3'd3,
        B_TYPE  = 3'd4,
        U_TYPE  = 3'd5,
        J_TYPE  = 3'd6
    } instr_format_t;
endpackage

module decode_stage_fwd
    import decode_stage_fwd_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    output logic [4:0]              reg_rd0,
    output logic [4:0]              reg_rd1,
    input  logic [XLEN-1:0]         reg_rd0_data,
    input  logic [XLEN-1:0]         reg_rd1_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [NUM_FWD-1:0]      fwd_data_ready,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [6:0]              out_opcode,
    output instr_format_t           out_instr_format,
    output logic [2:0]              out_funct3,
    output logic [6:0]              out_funct7,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [4:0]              out_rd,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_rs1_data,
    output logic [XLEN-1:0]         out_rs2_data,
    output logic                    out_illegal,
    output logic                    hazard_stall,
    output logic [CNT_W-1:0]        stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Resolve one source operand: {hazard, data}. The producer still sitting
    // in our own output register has not executed, so it always hazards; the
    // lowest-numbered matching bypass channel (youngest writer) wins.
    function automatic logic [XLEN:0] resolve_operand(
        input logic [4:0]              rs,
        input logic [XLEN-1:0]         rf_data,
        input logic                    busy,
        input logic [4:0]              busy_rd,
        input logic [NUM_FWD-1:0]      f_valid,
        input logic [5*NUM_FWD-1:0]    f_rd,
        input logic [NUM_FWD-1:0]      f_rdy,
        input logic [XLEN*NUM_FWD-1:0] f_data
    );
        logic            found;
        logic            hz;
        logic [XLEN-1:0] data;
        found = 1'b0;
        hz    = 1'b0;
        data  = rf_data;
        if (rs == 5'd0) begin
            data = {XLEN{1'b0}};
        end else if (busy && (busy_rd == rs)) begin
            hz   = 1'b1;
            data = {XLEN{1'b0}};
        end else begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!found && f_valid[i] && (f_rd[5*i +: 5] == rs)) begin
                    found = 1'b1;
                    if ((FWD_EN == 1) && f_rdy[i]) begin
                        data = f_data[XLEN*i +: XLEN];
                    end else begin
                        hz = 1'b1;
                    end
                end else begin
                    found = found;
                end
            end
        end
        return {hz, data};
    endfunction

    instr_format_t   fmt_s;
    logic            use_rs1_s;
    logic            use_rs2_s;
    logic            use_rd_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_s;
    logic            hz1_s;
    logic            hz2_s;
    logic [XLEN-1:0] op1_s;
    logic [XLEN-1:0] op2_s;
    logic            hazard_stall_s;
    logic            in_ready_s;

    logic            out_valid_d, out_valid_q;
    logic [6:0]      out_opcode_d, out_opcode_q;
    instr_format_t   out_fmt_d, out_fmt_q;
    logic [2:0]      out_funct3_d, out_funct3_q;
    logic [6:0]      out_funct7_d, out_funct7_q;
    logic [4:0]      out_rs1_d, out_rs1_q;
    logic [4:0]      out_rs2_d, out_rs2_q;
    logic [4:0]      out_rd_d, out_rd_q;
    logic [XLEN-1:0] out_imm_d, out_imm_q;
    logic [XLEN-1:0] out_rs1_data_d, out_rs1_data_q;
    logic [XLEN-1:0] out_rs2_data_d, out_rs2_data_q;
    logic            out_illegal_d, out_illegal_q;
    logic [CNT_W-1:0] stall_count_d, stall_count_q;

    // Classify the opcode into an instruction format.
    always_comb begin
        case (in_instr[6:0])
            7'b0110011: fmt_s = R_TYPE;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011: fmt_s = I_TYPE;
            7'b0100011: fmt_s = S_TYPE;
            7'b1100011: fmt_s = B_TYPE;
            7'b0110111,
            7'b0010111: fmt_s = U_TYPE;
            7'b1101111: fmt_s = J_TYPE;
            default:    fmt_s = NO_TYPE;
        endcase
    end

    // Per-format operand usage and raw 32-bit immediate assembly.
    always_comb begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        use_rd_s  = 1'b0;
        imm32_s   = 32'd0;
        case (fmt_s)
            R_TYPE: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                use_rd_s  = 1'b1;
            end
            I_TYPE: begin
                use_rs1_s = 1'b1;
                use_rd_s  = 1'b1;
                imm32_s   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            S_TYPE: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                imm32_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            B_TYPE: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                imm32_s   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            U_TYPE: begin
                use_rd_s  = 1'b1;
                imm32_s   = {in_instr[31:12], 12'd0};
            end
            J_TYPE: begin
                use_rd_s  = 1'b1;
                imm32_s   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
                use_rs1_s = 1'b0;
                use_rs2_s = 1'b0;
                use_rd_s  = 1'b0;
                imm32_s   = 32'd0;
            end
        endcase
    end

    // Register addresses (unused ones forced to x0) and operand resolution.
    always_comb begin
        if (use_rs1_s) begin
            rs1_s = in_instr[19:15];
        end else begin
            rs1_s = 5'd0;
        end
        if (use_rs2_s) begin
            rs2_s = in_instr[24:20];
        end else begin
            rs2_s = 5'd0;
        end
        if (use_rd_s) begin
            rd_s = in_instr[11:7];
        end else begin
            rd_s = 5'd0;
        end
        imm_s = XLEN'($signed(imm32_s));
        {hz1_s, op1_s} = resolve_operand(rs1_s, reg_rd0_data, out_valid_q, out_rd_q,
                                         fwd_valid, fwd_rd, fwd_data_ready, fwd_data);
        {hz2_s, op2_s} = resolve_operand(rs2_s, reg_rd1_data, out_valid_q, out_rd_q,
                                         fwd_valid, fwd_rd, fwd_data_ready, fwd_data);
        hazard_stall_s = in_valid && (hz1_s || hz2_s);
        in_ready_s     = !hazard_stall_s && (!out_valid_q || out_ready) && !flush;
    end

    // ID/EX next state: flush beats load beats hold; a hazard loads a bubble.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_opcode_d   = out_opcode_q;
        out_fmt_d      = out_fmt_q;
        out_funct3_d   = out_funct3_q;
        out_funct7_d   = out_funct7_q;
        out_rs1_d      = out_rs1_q;
        out_rs2_d      = out_rs2_q;
        out_rd_d       = out_rd_q;
        out_imm_d      = out_imm_q;
        out_rs1_data_d = out_rs1_data_q;
        out_rs2_data_d = out_rs2_data_q;
        out_illegal_d  = out_illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            out_valid_d    = in_valid && !hazard_stall_s;
            out_opcode_d   = in_instr[6:0];
            out_fmt_d      = fmt_s;
            out_funct3_d   = in_instr[14:12];
            out_funct7_d   = in_instr[31:25];
            out_rs1_d      = rs1_s;
            out_rs2_d      = rs2_s;
            out_rd_d       = rd_s;
            out_imm_d      = imm_s;
            out_rs1_data_d = op1_s;
            out_rs2_data_d = op2_s;
            out_illegal_d  = (fmt_s == NO_TYPE);
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stall counter advances on unflushed stall cycles and sticks at all-ones.
    always_comb begin
        if (hazard_stall_s && !flush && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_opcode_q   <= 7'd0;
            out_fmt_q      <= NO_TYPE;
            out_funct3_q   <= 3'd0;
            out_funct7_q   <= 7'd0;
            out_rs1_q      <= 5'd0;
            out_rs2_q      <= 5'd0;
            out_rd_q       <= 5'd0;
            out_imm_q      <= {XLEN{1'b0}};
            out_rs1_data_q <= {XLEN{1'b0}};
            out_rs2_data_q <= {XLEN{1'b0}};
            out_illegal_q  <= 1'b0;
            stall_count_q  <= {CNT_W{1'b0}};
        end else begin
            out_valid_q    <= out_valid_d;
            out_opcode_q   <= out_opcode_d;
            out_fmt_q      <= out_fmt_d;
            out_funct3_q   <= out_funct3_d;
            out_funct7_q   <= out_funct7_d;
            out_rs1_q      <= out_rs1_d;
            out_rs2_q      <= out_rs2_d;
            out_rd_q       <= out_rd_d;
            out_imm_q      <= out_imm_d;
            out_rs1_data_q <= out_rs1_data_d;
            out_rs2_data_q <= out_rs2_data_d;
            out_illegal_q  <= out_illegal_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign in_ready         = in_ready_s;
    assign hazard_stall     = hazard_stall_s;
    assign reg_rd0          = rs1_s;
    assign reg_rd1          = rs2_s;
    assign out_valid        = out_valid_q;
    assign out_opcode       = out_opcode_q;
    assign out_instr_format = out_fmt_q;
    assign out_funct3       = out_funct3_q;
    assign out_funct7       = out_funct7_q;
    assign out_rs1          = out_rs1_q;
    assign out_rs2          = out_rs2_q;
    assign out_rd           = out_rd_q;
    assign out_imm          = out_imm_q;
    assign out_rs1_data     = out_rs1_data_q;
    assign out_rs2_data     = out_rs2_data_q;
    assign out_illegal      = out_illegal_q;
    assign stall_count      = stall_count_q;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Directed bench for decode_stage_fwd: a decode vector table plus hand-written
// sequences for hazards, forwarding priority, flush, legacy mode and reset.
module tb_decode_stage_fwd;
    import decode_stage_fwd_pkg::*;

    logic clk;
    logic rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, rd0_data, rd1_data;
    logic [1:0]  fwd_valid, fwd_rdy;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;

    logic in_ready, out_valid, out_illegal, hazard_stall;
    logic [4:0] reg_rd0, reg_rd1, out_rs1, out_rs2, out_rd;
    logic [6:0] out_opcode, out_funct7;
    logic [2:0] out_funct3;
    instr_format_t out_fmt;
    logic [31:0] out_imm, out_rs1_data, out_rs2_data, stall_count;

    logic l_in_ready, l_out_valid, l_out_illegal, l_hazard;
    logic [4:0] l_rd0, l_rd1, l_rs1, l_rs2, l_rd;
    logic [6:0] l_opcode, l_funct7;
    logic [2:0] l_funct3;
    instr_format_t l_fmt;
    logic [31:0] l_imm, l_d1, l_d2;
    logic [1:0]  l_count;

    int n_cmp = 0;
    int n_fail = 0;

    decode_stage_fwd u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .reg_rd0(reg_rd0), .reg_rd1(reg_rd1),
        .reg_rd0_data(rd0_data), .reg_rd1_data(rd1_data), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data_ready(fwd_rdy), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_instr_format(out_fmt), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_illegal(out_illegal), .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    decode_stage_fwd #(.FWD_EN(0), .CNT_W(2)) u_leg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_instr(in_instr), .reg_rd0(l_rd0), .reg_rd1(l_rd1),
        .reg_rd0_data(rd0_data), .reg_rd1_data(rd1_data), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data_ready(fwd_rdy), .fwd_data(fwd_data),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_opcode(l_opcode),
        .out_instr_format(l_fmt), .out_funct3(l_funct3), .out_funct7(l_funct7),
        .out_rs1(l_rs1), .out_rs2(l_rs2), .out_rd(l_rd), .out_imm(l_imm),
        .out_rs1_data(l_d1), .out_rs2_data(l_d2),
        .out_illegal(l_out_illegal), .hazard_stall(l_hazard), .stall_count(l_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   instr;
        logic [31:0]   d0;
        logic [31:0]   d1;
        logic [4:0]    e_rd0;
        logic [4:0]    e_rd1;
        logic [4:0]    e_rd;
        logic [31:0]   e_imm;
        instr_format_t e_fmt;
        logic          e_ill;
        logic [31:0]   e_op1;
        logic [31:0]   e_op2;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h002081B3, 32'd5,      32'd7,      5'd1, 5'd2, 5'd3, 32'h0,        R_TYPE,  1'b0, 32'd5,      32'd7};
        vecs[1] = '{32'hFFF18213, 32'h100,    32'h200,    5'd3, 5'd0, 5'd4, 32'hFFFFFFFF, I_TYPE,  1'b0, 32'h100,    32'h0};
        vecs[2] = '{32'h0020A423, 32'h1000,   32'hCAFE,   5'd1, 5'd2, 5'd0, 32'h8,        S_TYPE,  1'b0, 32'h1000,   32'hCAFE};
        vecs[3] = '{32'hFE208EE3, 32'd3,      32'd4,      5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, B_TYPE,  1'b0, 32'd3,      32'd4};
        vecs[4] = '{32'h001000EF, 32'd9,      32'd9,      5'd0, 5'd0, 5'd1, 32'h800,      J_TYPE,  1'b0, 32'h0,      32'h0};
        vecs[5] = '{32'h123453B7, 32'd9,      32'd9,      5'd0, 5'd0, 5'd7, 32'h12345000, U_TYPE,  1'b0, 32'h0,      32'h0};
        vecs[6] = '{32'h00500493, 32'h55,     32'h66,     5'd0, 5'd0, 5'd9, 32'h5,        I_TYPE,  1'b0, 32'h0,      32'h0};
        vecs[7] = '{32'h002081FF, 32'd1,      32'd2,      5'd0, 5'd0, 5'd0, 32'h0,        NO_TYPE, 1'b1, 32'h0,      32'h0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; rd0_data = 32'd0; rd1_data = 32'd0;
        fwd_valid = 2'b00; fwd_rdy = 2'b00; fwd_rd = 10'd0; fwd_data = 64'd0;
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_fmt", 64'(out_fmt), 64'(NO_TYPE));
        check("rst_stall_count", 64'(stall_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // Decode table: one instruction, then an idle cycle to drain.
        for (int i = 0; i < 8; i++) begin
            in_instr = vecs[i].instr; rd0_data = vecs[i].d0; rd1_data = vecs[i].d1;
            in_valid = 1'b1;
            #1;
            check("tbl_reg_rd0", 64'(reg_rd0), 64'(vecs[i].e_rd0));
            check("tbl_reg_rd1", 64'(reg_rd1), 64'(vecs[i].e_rd1));
            check("tbl_no_stall", 64'(hazard_stall), 64'd0);
            tick();
            in_valid = 1'b0;
            check("tbl_out_valid", 64'(out_valid), 64'd1);
            check("tbl_out_rd", 64'(out_rd), 64'(vecs[i].e_rd));
            check("tbl_out_imm", 64'(out_imm), 64'(vecs[i].e_imm));
            check("tbl_out_fmt", 64'(out_fmt), 64'(vecs[i].e_fmt));
            check("tbl_out_illegal", 64'(out_illegal), 64'(vecs[i].e_ill));
            check("tbl_rs1_data", 64'(out_rs1_data), 64'(vecs[i].e_op1));
            check("tbl_rs2_data", 64'(out_rs2_data), 64'(vecs[i].e_op2));
            tick();
        end
        check("tbl_stall_count", 64'(stall_count), 64'd0);

        // Hazard against the instruction held in the output register.
        in_instr = 32'hFFF18213; rd0_data = 32'h3; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check("a_held_valid", 64'(out_valid), 64'd1);
        check("a_held_rd", 64'(out_rd), 64'd4);
        in_instr = 32'h000202B3;
        #1;
        check("a_hazard", 64'(hazard_stall), 64'd1);
        check("a_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("a_count1", 64'(stall_count), 64'd1);
        check("a_hold_rd", 64'(out_rd), 64'd4);
        tick();
        check("a_count2", 64'(stall_count), 64'd2);
        out_ready = 1'b1;
        #1;
        check("a_hazard_ready", 64'(hazard_stall), 64'd1);
        tick();
        check("a_bubble", 64'(out_valid), 64'd0);
        check("a_count3", 64'(stall_count), 64'd3);
        fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd4}; fwd_rdy = 2'b01; fwd_data = {32'h0, 32'h10};
        #1;
        check("a_fwd_no_hazard", 64'(hazard_stall), 64'd0);
        check("a_fwd_in_ready", 64'(in_ready), 64'd1);
        check("a_leg_hazard", 64'(l_hazard), 64'd1);
        tick();
        check("a_fwd_valid", 64'(out_valid), 64'd1);
        check("a_fwd_data", 64'(out_rs1_data), 64'h10);
        check("a_fwd_rd", 64'(out_rd), 64'd5);
        check("a_count_stable", 64'(stall_count), 64'd3);
        check("a_leg_valid", 64'(l_out_valid), 64'd0);

        // Youngest channel has priority even when it is not ready.
        in_valid = 1'b0; fwd_valid = 2'b00;
        tick();
        in_instr = 32'h000303B3; in_valid = 1'b1;
        fwd_valid = 2'b11; fwd_rd = {5'd6, 5'd6}; fwd_rdy = 2'b10; fwd_data = {32'hAA, 32'h0};
        #1;
        check("b_prio_stall", 64'(hazard_stall), 64'd1);
        tick();
        check("b_count4", 64'(stall_count), 64'd4);
        check("b_stall_valid", 64'(out_valid), 64'd0);
        fwd_rdy = 2'b11; fwd_data = {32'hAA, 32'hBB};
        #1;
        check("b_ready_no_stall", 64'(hazard_stall), 64'd0);
        check("b_leg_stall", 64'(l_hazard), 64'd1);
        tick();
        check("b_fwd_valid", 64'(out_valid), 64'd1);
        check("b_fwd_ch0", 64'(out_rs1_data), 64'hBB);
        check("b_leg_valid", 64'(l_out_valid), 64'd0);
        check("b_leg_saturate", 64'(l_count), 64'd3);
        fwd_valid = 2'b10;
        tick();
        check("b_fwd_ch1", 64'(out_rs1_data), 64'hAA);

        // Flush with a valid input: input refused, output killed.
        fwd_valid = 2'b00;
        in_instr = 32'h002081B3; rd0_data = 32'd5; rd1_data = 32'd7;
        tick();
        check("c_loaded", 64'(out_valid), 64'd1);
        flush = 1'b1; in_instr = 32'h123453B7;
        #1;
        check("c_flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        check("c_flush_valid", 64'(out_valid), 64'd0);
        check("c_flush_count", 64'(stall_count), 64'd4);

        // Illegal opcode never stalls even with matching bypass channels.
        in_instr = 32'h002081FF; fwd_valid = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_rdy = 2'b00;
        #1;
        check("d_ill_no_stall", 64'(hazard_stall), 64'd0);
        check("d_ill_leg_no_stall", 64'(l_hazard), 64'd0);
        check("d_ill_rd0", 64'(reg_rd0), 64'd0);
        check("d_ill_rd1", 64'(reg_rd1), 64'd0);
        tick();
        check("d_ill_valid", 64'(out_valid), 64'd1);
        check("d_ill_flag", 64'(out_illegal), 64'd1);

        // Reset mid-stream clears everything on the next edge.
        fwd_valid = 2'b00; in_instr = 32'h001000EF;
        tick();
        check("e_jal_imm", 64'(out_imm), 64'h800);
        rst_n = 1'b0;
        tick();
        check("e_rst_valid", 64'(out_valid), 64'd0);
        check("e_rst_rd", 64'(out_rd), 64'd0);
        check("e_rst_imm", 64'(out_imm), 64'd0);
        check("e_rst_fmt", 64'(out_fmt), 64'(NO_TYPE));
        check("e_rst_count", 64'(stall_count), 64'd0);
        check("e_rst_leg_count", 64'(l_count), 64'd0);
        in_valid = 1'b0; rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
